// File: rtl/wb_regfile.sv
// Write-back stage of the RV32 pipeline: selects the write-back value, commits it to
// the 32x32 architectural register file, and provides a registered commit trace and instret.
module wb_regfile #(
    parameter int CNT_W = 32
) (
    input  logic             clk_WB,
    input  logic             rst_WB,
    input  logic             valid_in_WB,
    input  logic [31:0]      PC4_in_WB,
    input  logic [4:0]       Rd_addr_in_WB,
    input  logic [31:0]      ALU_in_WB,
    input  logic [31:0]      DMem_data_in_WB,
    input  logic [1:0]       MemtoReg_in_WB,
    input  logic             RegWrite_in_WB,
    input  logic [31:0]      pc_in_WB,
    input  logic [31:0]      inst_in_WB,
    input  logic [4:0]       Rs1_addr_WB,
    input  logic [4:0]       Rs2_addr_WB,
    output logic [31:0]      Rs1_data_WB,
    output logic [31:0]      Rs2_data_WB,
    output logic [31:0]      Wt_data_WB,
    input  logic [4:0]       dbg_addr_WB,
    output logic [31:0]      dbg_data_WB,
    output logic             commit_valid_WB,
    output logic [31:0]      commit_pc_WB,
    output logic [31:0]      commit_inst_WB,
    output logic [4:0]       commit_rd_WB,
    output logic [31:0]      commit_data_WB,
    output logic [CNT_W-1:0] instret_WB
);

    // x0 is not stored; the array covers x1..x31 only.
    logic [31:0]      regs_q [1:31];
    logic [31:0]      regs_d [1:31];
    logic             we;
    logic [31:0]      wt_data;

    logic             commit_valid_q, commit_valid_d;
    logic [31:0]      commit_pc_q, commit_pc_d;
    logic [31:0]      commit_inst_q, commit_inst_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_data_q, commit_data_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        wt_data = 32'h0;
        case (MemtoReg_in_WB)
            2'b00:   wt_data = ALU_in_WB;
            2'b01:   wt_data = DMem_data_in_WB;
            2'b10:   wt_data = PC4_in_WB;
            default: wt_data = 32'h0;
        endcase
    end

    assign we = valid_in_WB & RegWrite_in_WB & (Rd_addr_in_WB != 5'd0) & ~rst_WB;

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (Rd_addr_in_WB == 5'(i)))
                regs_d[i] = wt_data;
        end
    end

    // Write-first bypass so ID sees the value being written this cycle.
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] val;
        val = 32'h0;
        if (addr != 5'd0) begin
            if (we && (addr == Rd_addr_in_WB))
                val = wt_data;
            else
                val = regs_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        Rs1_data_WB = read_port(Rs1_addr_WB);
        Rs2_data_WB = read_port(Rs2_addr_WB);
        dbg_data_WB = 32'h0;
        if (dbg_addr_WB != 5'd0)
            dbg_data_WB = regs_q[dbg_addr_WB];
    end

    always_comb begin
        commit_valid_d = 1'b0;
        commit_pc_d    = 32'h0;
        commit_inst_d  = 32'h0;
        commit_rd_d    = 5'd0;
        commit_data_d  = 32'h0;
        instret_d      = instret_q;
        if (valid_in_WB) begin
            commit_valid_d = 1'b1;
            commit_pc_d    = pc_in_WB;
            commit_inst_d  = inst_in_WB;
            instret_d      = instret_q + CNT_W'(1);
            if (we) begin
                commit_rd_d   = Rd_addr_in_WB;
                commit_data_d = wt_data;
            end
        end
    end

    always_ff @(posedge clk_WB) begin
        if (rst_WB) begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= 32'h0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= 32'h0;
            commit_inst_q  <= 32'h0;
            commit_rd_q    <= 5'd0;
            commit_data_q  <= 32'h0;
            instret_q      <= '0;
        end else begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= regs_d[i];
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_inst_q  <= commit_inst_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
            instret_q      <= instret_d;
        end
    end

    assign Wt_data_WB      = wt_data;
    assign commit_valid_WB = commit_valid_q;
    assign commit_pc_WB    = commit_pc_q;
    assign commit_inst_WB  = commit_inst_q;
    assign commit_rd_WB    = commit_rd_q;
    assign commit_data_WB  = commit_data_q;
    assign instret_WB      = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a 32-bit counter instance plus a 4-bit counter
// instance (for wrap) share all stimulus.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] dmem;
    logic [1:0]  m2r;
    logic        rw;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, dbg_a;

    logic [31:0] rs1_d, rs2_d, wt_d, dbg_d, cpc, cinst, cdata;
    logic        cvalid;
    logic [4:0]  crd;
    logic [31:0] instret;

    logic [31:0] rs1_d4, rs2_d4, wt_d4, dbg_d4, cpc4, cinst4, cdata4;
    logic        cvalid4;
    logic [4:0]  crd4;
    logic [3:0]  instret4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_regfile #(.CNT_W(32)) dut (
        .clk_WB(clk), .rst_WB(rst), .valid_in_WB(valid), .PC4_in_WB(pc4),
        .Rd_addr_in_WB(rd), .ALU_in_WB(alu), .DMem_data_in_WB(dmem),
        .MemtoReg_in_WB(m2r), .RegWrite_in_WB(rw), .pc_in_WB(pc), .inst_in_WB(inst),
        .Rs1_addr_WB(rs1), .Rs2_addr_WB(rs2), .Rs1_data_WB(rs1_d), .Rs2_data_WB(rs2_d),
        .Wt_data_WB(wt_d), .dbg_addr_WB(dbg_a), .dbg_data_WB(dbg_d),
        .commit_valid_WB(cvalid), .commit_pc_WB(cpc), .commit_inst_WB(cinst),
        .commit_rd_WB(crd), .commit_data_WB(cdata), .instret_WB(instret)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk_WB(clk), .rst_WB(rst), .valid_in_WB(valid), .PC4_in_WB(pc4),
        .Rd_addr_in_WB(rd), .ALU_in_WB(alu), .DMem_data_in_WB(dmem),
        .MemtoReg_in_WB(m2r), .RegWrite_in_WB(rw), .pc_in_WB(pc), .inst_in_WB(inst),
        .Rs1_addr_WB(rs1), .Rs2_addr_WB(rs2), .Rs1_data_WB(rs1_d4), .Rs2_data_WB(rs2_d4),
        .Wt_data_WB(wt_d4), .dbg_addr_WB(dbg_a), .dbg_data_WB(dbg_d4),
        .commit_valid_WB(cvalid4), .commit_pc_WB(cpc4), .commit_inst_WB(cinst4),
        .commit_rd_WB(crd4), .commit_data_WB(cdata4), .instret_WB(instret4)
    );

    // Inputs change 1 time unit after the rising edge; checks happen 1-2 units later.
    task automatic drive(input logic v, input logic w, input logic [4:0] r,
                         input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p4);
        valid = v; rw = w; rd = r; m2r = m; alu = a; dmem = d; pc4 = p4;
        pc = p4 - 32'd4; inst = 32'h0000_0013 | {20'h0, r, 7'h0};
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 5'd5, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0000_0010);
        dbg_a = 5'd5;
        step;
        n_tests++;
        if (dbg_d !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL preload_x5 got %h want %h", dbg_d, 32'hDEAD_BEEF);
        end
        rst = 1'b1;
        step;
        rst = 1'b0; idle;
        #1;
        n_tests++;
        if (dbg_d !== 32'h0) begin n_fail++; $display("FAIL reset_x5 got %h want 0", dbg_d); end
        n_tests++;
        if (instret !== 32'h0 || instret4 !== 4'h0) begin
            n_fail++; $display("FAIL reset_instret got %0d/%0d want 0", instret, instret4);
        end
        n_tests++;
        if (cvalid !== 1'b0 || crd !== 5'd0 || cdata !== 32'h0 || cpc !== 32'h0) begin
            n_fail++; $display("FAIL reset_commit got v=%b rd=%0d d=%h pc=%h want 0", cvalid, crd, cdata, cpc);
        end
    endtask

    task automatic test_mux_write;
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0BAD_0BAD, 32'h1234_5678, 32'h0000_0100);
        rs1 = 5'd3; dbg_a = 5'd3;
        #1;
        n_tests++;
        if (rs1_d !== 32'h1234_5678 || wt_d !== 32'h1234_5678) begin
            n_fail++; $display("FAIL mux01_bypass got rs1=%h wt=%h want 12345678", rs1_d, wt_d);
        end
        n_tests++;
        if (dbg_d !== 32'h0) begin n_fail++; $display("FAIL dbg_no_bypass got %h want 0", dbg_d); end
        step;
        drive(1'b1, 1'b1, 5'd3, 2'b10, 32'h0BAD_0BAD, 32'hFFFF_0000, 32'h0000_0104);
        n_tests++;
        if (dbg_d !== 32'h1234_5678 || crd !== 5'd3 || cdata !== 32'h1234_5678 || instret !== 32'd1) begin
            n_fail++; $display("FAIL commit_load got x3=%h rd=%0d d=%h n=%0d want 12345678/3/12345678/1", dbg_d, crd, cdata, instret);
        end
        n_tests++;
        if (cvalid !== 1'b1 || cpc !== 32'h0000_00FC || cinst !== 32'h0000_0193) begin
            n_fail++; $display("FAIL commit_pc got v=%b pc=%h inst=%h want 1/000000fc/00000193", cvalid, cpc, cinst);
        end
        #1;
        n_tests++;
        if (rs1_d !== 32'h0000_0104) begin n_fail++; $display("FAIL mux10_bypass got %h want 104", rs1_d); end
        step;
        idle;
        n_tests++;
        if (dbg_d !== 32'h0000_0104 || instret !== 32'd2) begin
            n_fail++; $display("FAIL mux10_commit got x3=%h n=%0d want 104/2", dbg_d, instret);
        end
        m2r = 2'b00; alu = 32'hCAFE_0001; dmem = 32'h5; pc4 = 32'h9;
        #1;
        n_tests++;
        if (wt_d !== 32'hCAFE_0001) begin n_fail++; $display("FAIL mux00 got %h want cafe0001", wt_d); end
        m2r = 2'b11;
        #1;
        n_tests++;
        if (wt_d !== 32'h0) begin n_fail++; $display("FAIL mux11 got %h want 0", wt_d); end
    endtask

    task automatic test_x0;
        drive(1'b1, 1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0000_0200);
        rs1 = 5'd0; rs2 = 5'd0; dbg_a = 5'd0;
        #1;
        n_tests++;
        if (rs1_d !== 32'h0 || rs2_d !== 32'h0) begin
            n_fail++; $display("FAIL x0_read got %h/%h want 0/0", rs1_d, rs2_d);
        end
        step;
        idle;
        n_tests++;
        if (crd !== 5'd0 || cdata !== 32'h0 || cvalid !== 1'b1 || instret !== 32'd3 || dbg_d !== 32'h0) begin
            n_fail++; $display("FAIL x0_commit got rd=%0d d=%h v=%b n=%0d dbg=%h want 0/0/1/3/0", crd, cdata, cvalid, instret, dbg_d);
        end
    endtask

    task automatic test_bubble;
        drive(1'b0, 1'b1, 5'd7, 2'b00, 32'h0000_00AA, 32'h0, 32'h0000_0300);
        rs2 = 5'd7; dbg_a = 5'd7;
        #1;
        n_tests++;
        if (rs2_d !== 32'h0) begin n_fail++; $display("FAIL bubble_bypass got %h want 0", rs2_d); end
        step;
        idle;
        n_tests++;
        if (dbg_d !== 32'h0 || instret !== 32'd3 || cvalid !== 1'b0 || cpc !== 32'h0 || cinst !== 32'h0) begin
            n_fail++; $display("FAIL bubble_state got x7=%h n=%0d v=%b pc=%h inst=%h want 0/3/0/0/0", dbg_d, instret, cvalid, cpc, cinst);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 5'd4, 2'b00, 32'h0000_0011, 32'h0, 32'h0000_0400);
        rs1 = 5'd4; rs2 = 5'd4; dbg_a = 5'd4;
        #1;
        n_tests++;
        if (rs1_d !== 32'h11) begin n_fail++; $display("FAIL b2b_first got %h want 11", rs1_d); end
        step;
        drive(1'b1, 1'b1, 5'd4, 2'b00, 32'h0000_0022, 32'h0, 32'h0000_0404);
        #1;
        n_tests++;
        if (rs1_d !== 32'h22 || rs2_d !== 32'h22 || dbg_d !== 32'h11) begin
            n_fail++; $display("FAIL b2b_second got rs1=%h rs2=%h dbg=%h want 22/22/11", rs1_d, rs2_d, dbg_d);
        end
        step;
        idle;
        n_tests++;
        if (dbg_d !== 32'h22 || crd !== 5'd4 || cdata !== 32'h22 || instret !== 32'd5) begin
            n_fail++; $display("FAIL b2b_final got x4=%h rd=%0d d=%h n=%0d want 22/4/22/5", dbg_d, crd, cdata, instret);
        end
    endtask

    task automatic test_wrap;
        rst = 1'b1; step; rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 5'd1, 2'b00, 32'h0, 32'h0, 32'h1000 + 32'(4 * i));
            step;
        end
        idle;
        n_tests++;
        if (instret4 !== 4'd1 || instret !== 32'd17) begin
            n_fail++; $display("FAIL wrap got %0d/%0d want 1/17", instret4, instret);
        end
    endtask

    task automatic test_midreset;
        drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0055, 32'h0, 32'h0000_0500);
        rs1 = 5'd9; dbg_a = 5'd9;
        step;
        drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0099, 32'h0, 32'h0000_0504);
        rst = 1'b1;
        #1;
        n_tests++;
        if (rs1_d !== 32'h55 || dbg_d !== 32'h55) begin
            n_fail++; $display("FAIL midrst_nobypass got rs1=%h dbg=%h want 55/55", rs1_d, dbg_d);
        end
        step;
        rst = 1'b0; idle;
        n_tests++;
        if (dbg_d !== 32'h0 || instret !== 32'd0 || instret4 !== 4'd0 || cvalid !== 1'b0 || crd !== 5'd0) begin
            n_fail++; $display("FAIL midrst got x9=%h n=%0d/%0d v=%b rd=%0d want 0/0/0/0/0", dbg_d, instret, instret4, cvalid, crd);
        end
    endtask

    initial begin
        rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; dbg_a = 5'd0;
        idle;
        step; step;
        rst = 1'b0;
        test_reset;
        test_mux_write;
        test_x0;
        test_bubble;
        test_back_to_back;
        test_wrap;
        test_midreset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage RV32 pipeline, placed directly downstream of the MEM/WB pipeline register and consuming its outputs. It selects the write-back value and commits it to a 32×32 register file (x0 hard-wired to zero). It serves the ID stage's two read ports with same-cycle write bypass and exposes a registered commit trace plus a retired-instruction counter for debug and verification.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk_WB  in  1  single clock; all state updates on rising edge
- rst_WB  in  1  synchronous, active-high reset
- valid_in_WB  in  1  instruction in WB is valid (not a bubble)
- PC4_in_WB  in  32  PC+4 of WB instruction
- Rd_addr_in_WB  in  5  destination register
- ALU_in_WB  in  32  ALU result
- DMem_data_in_WB  in  32  load data
- MemtoReg_in_WB  in  2  write-back select
- RegWrite_in_WB  in  1  register write request
- pc_in_WB  in  32  PC of WB instruction
- inst_in_WB  in  32  instruction word
- Rs1_addr_WB, Rs2_addr_WB  in  5  ID read addresses
- Rs1_data_WB, Rs2_data_WB  out  32  ID read data (combinational)
- Wt_data_WB  out  32  selected write-back value (combinational, for EX forwarding)
- dbg_addr_WB  in  5  debug read address
- dbg_data_WB  out  32  debug read data (combinational, no bypass)
- commit_valid_WB  out  1  registered: an instruction retired last cycle
- commit_pc_WB, commit_inst_WB  out  32  registered PC / instruction of that retirement
- commit_rd_WB  out  5  registered rd (0 if no write)
- commit_data_WB  out  32  registered written value (0 if no write)
- instret_WB  out  CNT_W  retired-instruction count

## Operation
- Write-back mux (Wt_data_WB): MemtoReg 2'b00 → ALU_in_WB; 2'b01 → DMem_data_in_WB; 2'b10 → PC4_in_WB; 2'b11 → 32'h0.
- Write enable we = valid_in_WB & RegWrite_in_WB & (Rd_addr_in_WB != 0) & ~rst_WB.
- On rising edge with we: regs[Rd_addr_in_WB] <= Wt_data_WB. x0 never stored; reads of address 0 return 0.
- Read ports: address 0 → 0; else if we and address == Rd_addr_in_WB → Wt_data_WB (write-first bypass); else regs[address]. Both ports bypass independently.
- dbg_data_WB: regs[dbg_addr_WB] only (0 for address 0); shows the value after the edge, no bypass.
- Commit trace, registered each edge: commit_valid_WB <= valid_in_WB; commit_pc_WB <= pc_in_WB; commit_inst_WB <= inst_in_WB; commit_rd_WB <= we ? Rd_addr_in_WB : 0; commit_data_WB <= we ? Wt_data_WB : 0. When valid_in_WB = 0, all commit outputs load 0.
- instret_WB increments by 1 on each edge with valid_in_WB = 1, independent of RegWrite. Wraps modulo 2^CNT_W (all-ones → 0).

## Timing
- Reset (synchronous): on an edge with rst_WB = 1, all 31 registers ← 0, instret_WB ← 0, and all commit_* ← 0. Inputs in that cycle are ignored; no write, no count.
- Reset asserted mid-stream: the instruction present during the reset edge is dropped and never retired.
- Write latency: a value is visible on read ports combinationally in the write cycle (bypass), and in the array from the next cycle.
- Commit trace and instret: 1-cycle latency after the retiring cycle.
- Back-to-back writes to the same rd: the later write wins, and each is bypassed in its own cycle.
- Simultaneous read of x0 while writing rd = 0: returns 0; the array is unchanged.
- Bubble (valid_in_WB = 0) with RegWrite_in_WB = 1: no write, no count, and no bypass.

## Test plan
- Reset: preload x5 = 32'hDEAD_BEEF, assert rst_WB for one edge → dbg(x5) = 0, instret_WB = 0, commit_valid_WB = 0.
- Mux and write: valid, RegWrite, rd = 3, MemtoReg = 01, DMem = 32'h1234_5678 → Rs1_data(addr 3) = 32'h1234_5678 in the same cycle. The next cycle shows dbg(x3) = 32'h1234_5678, commit_rd = 3, and instret = 1. Repeat with MemtoReg 10 and PC4 = 32'h0000_0104 → x3 = 32'h104.
- x0 protection: write rd = 0, ALU = 32'hFFFF_FFFF, with Rs1 = Rs2 = 0 → both reads 0. Commit_rd = 0 and commit_data = 0, and instret still increments.
- Bubble: valid = 0, RegWrite = 1, rd = 7, ALU = 32'hAA → x7 unchanged, no bypass on Rs2 = 7, and instret unchanged.
- Wrap: CNT_W = 4, 17 valid instructions → instret_WB = 1.
- Mid-stream reset: valid write to x9 coinciding with rst_WB = 1 → x9 = 0 and instret = 0 afterwards.
